spi_rx_scanner: RTL and testbench

- Parametrised, multi-channel, read-only SPI master for MAX6675-class serial sensors (thermocouple converters, ADCs) that only clock data out.
- Scans up to NUM_CH devices sharing SCLK/MISO, each with its own chip select.
- Captures one FRAME_BITS-wide word per enabled channel, MSB-first, and presents each word with a channel tag and a one-cycle valid strobe.
- Fully synchronous to clk; SCLK is generated as a registered output. It sits between the sensor pins and the sample-processing logic (filters, FIR).

---
 rtl/spi_rx_scanner.sv | 213 +++++++++++++++++++++
 tb/tb_spi_rx_scanner.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_scanner.sv
// Read-only multi-channel SPI master scanning MAX6675-class sensors, one frame per enabled channel.
// Optional SPI_RX_SCANNER_FAULT_EN adds parameter FAULT_BIT and a per-channel fault output.
module spi_rx_scanner #(
    parameter int unsigned CLK_DIV_HALF = 300,
    parameter int unsigned CS_SETUP     = 300,
    parameter int unsigned CS_HOLD      = 600,
    parameter int unsigned FRAME_BITS   = 16,
    parameter int unsigned NUM_CH       = 4,
`ifdef SPI_RX_SCANNER_FAULT_EN
    parameter int unsigned FAULT_BIT    = 2,
`endif
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic                  miso,
    output logic                  sclk,
    output logic [NUM_CH-1:0]     cs_n,
    output logic                  idle,
    output logic                  busy,
    output logic                  data_valid,
    output logic [CH_W-1:0]       data_ch,
    output logic [FRAME_BITS-1:0] data,
`ifdef SPI_RX_SCANNER_FAULT_EN
    output logic [NUM_CH-1:0]     fault,
`endif
    output logic                  done
);

    localparam int unsigned CNT_MAX0 = (CLK_DIV_HALF > CS_SETUP) ? CLK_DIV_HALF : CS_SETUP;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > CS_HOLD) ? CNT_MAX0 : CS_HOLD;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W    = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SETUP, S_HIGH, S_LOW, S_CAPTURE, S_HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bits_q, bits_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [NUM_CH-1:0]     pend_q, pend_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  sclk_q, sclk_d;
    logic [NUM_CH-1:0]     cs_n_q, cs_n_d;
    logic                  idle_q, idle_d;
    logic                  busy_q, busy_d;
    logic                  dv_q, dv_d;
    logic                  done_q, done_d;
    logic [CH_W-1:0]       data_ch_q, data_ch_d;
    logic [FRAME_BITS-1:0] data_q, data_d;
    logic [CH_W-1:0]       sel;
`ifdef SPI_RX_SCANNER_FAULT_EN
    logic [NUM_CH-1:0]     fault_q, fault_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bits_d    = bits_q;
        ch_d      = ch_q;
        pend_d    = pend_q;
        shift_d   = shift_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        dv_d      = 1'b0;
        done_d    = 1'b0;
        data_ch_d = data_ch_q;
        data_d    = data_q;
`ifdef SPI_RX_SCANNER_FAULT_EN
        fault_d   = fault_q;
`endif
        // Lowest-index pending channel wins
        sel = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (pend_q[i-1]) sel = CH_W'(i - 1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pend_d  = ch_mask;
                    state_d = S_SELECT;
`ifdef SPI_RX_SCANNER_FAULT_EN
                    fault_d = '0;
`endif
                end
            end
            S_SELECT: begin
                if (pend_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    ch_d         = sel;
                    pend_d[sel]  = 1'b0;
                    cs_n_d       = '1;
                    cs_n_d[sel]  = 1'b0;
                    sclk_d       = 1'b0;
                    bits_d       = '0;
                    cnt_d        = CNT_W'(CS_SETUP - 1);
                    state_d      = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    sclk_d  = 1'b1;
                    cnt_d   = CNT_W'(CLK_DIV_HALF - 1);
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    sclk_d  = 1'b0;
                    shift_d = {shift_q[FRAME_BITS-2:0], miso};
                    bits_d  = bits_q + BIT_W'(1);
                    cnt_d   = CNT_W'(CLK_DIV_HALF - 1);
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (bits_q == BIT_W'(FRAME_BITS)) begin
                    cs_n_d  = '1;
                    state_d = S_CAPTURE;
                end else begin
                    sclk_d  = 1'b1;
                    cnt_d   = CNT_W'(CLK_DIV_HALF - 1);
                    state_d = S_HIGH;
                end
            end
            // cs_n is already high here; this cycle only publishes the word, then hold starts
            S_CAPTURE: begin
                data_d    = shift_q;
                data_ch_d = ch_q;
                dv_d      = 1'b1;
`ifdef SPI_RX_SCANNER_FAULT_EN
                fault_d[ch_q] = shift_q[FAULT_BIT];
`endif
                cnt_d     = CNT_W'(CS_HOLD - 1);
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == '0) state_d = S_SELECT;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        idle_d = (state_d == S_IDLE);
        busy_d = ~idle_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bits_q    <= '0;
            ch_q      <= '0;
            pend_q    <= '0;
            shift_q   <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= '1;
            idle_q    <= 1'b1;
            busy_q    <= 1'b0;
            dv_q      <= 1'b0;
            done_q    <= 1'b0;
            data_ch_q <= '0;
            data_q    <= '0;
`ifdef SPI_RX_SCANNER_FAULT_EN
            fault_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bits_q    <= bits_d;
            ch_q      <= ch_d;
            pend_q    <= pend_d;
            shift_q   <= shift_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            idle_q    <= idle_d;
            busy_q    <= busy_d;
            dv_q      <= dv_d;
            done_q    <= done_d;
            data_ch_q <= data_ch_d;
            data_q    <= data_d;
`ifdef SPI_RX_SCANNER_FAULT_EN
            fault_q   <= fault_d;
`endif
        end
    end

    assign sclk       = sclk_q;
    assign cs_n       = cs_n_q;
    assign idle       = idle_q;
    assign busy       = busy_q;
    assign data_valid = dv_q;
    assign done       = done_q;
    assign data_ch    = data_ch_q;
    assign data       = data_q;
`ifdef SPI_RX_SCANNER_FAULT_EN
    assign fault      = fault_q;
`endif

endmodule

// File: tb/tb_spi_rx_scanner.sv
// Self-checking bench for spi_rx_scanner: sensor MISO model plus a timing/order reference model.
`timescale 1ns/1ps
module tb_spi_rx_scanner;

    localparam int CDH = 2;
    localparam int CSS = 3;
    localparam int CSH = 4;
    localparam int FB  = 16;
    localparam int NCH = 4;
    // Per channel: select cycle, setup, FB sclk periods, capture cycle, hold
    localparam int FRAME_PERIOD = 1 + CSS + 2 * CDH * FB + 1 + CSH;
    // Strobe seen one cycle after it is registered on hold entry
    localparam int DV_OFS       = 1 + CSS + 2 * CDH * FB + 1 + 1;

    logic          clk = 1'b0;
    logic          rst, start, miso;
    logic [3:0]    ch_mask;
    logic          sclk, idle, busy, data_valid, done;
    logic [3:0]    cs_n;
    logic [1:0]    data_ch;
    logic [15:0]   data;
`ifdef SPI_RX_SCANNER_FAULT_EN
    logic [3:0]    fault;
    logic [3:0]    obs_fault_k2, obs_fault_end;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] words [NCH];
    int          obs_dv_k[$], obs_dv_ch[$], obs_done_k[$];
    logic [15:0] obs_dv_data[$];
    int          exp_dv_k[$], exp_dv_ch[$], exp_done_k[$];
    logic [15:0] exp_dv_data[$];
    int          obs_rises, obs_multi_low, obs_bad_high, obs_min_gap;
    bit          obs_any_cs_low, obs_aborted;
    logic [3:0]  obs_cs_k2, snap_cs;
    logic        snap_sclk, snap_idle, snap_busy, snap_dv, snap_done;
    logic [15:0] obs_data_start, obs_data_end;

    spi_rx_scanner #(
        .CLK_DIV_HALF(CDH),
        .CS_SETUP    (CSS),
        .CS_HOLD     (CSH),
        .FRAME_BITS  (FB),
`ifdef SPI_RX_SCANNER_FAULT_EN
        .FAULT_BIT   (2),
`endif
        .NUM_CH      (NCH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ch_mask   (ch_mask),
        .miso      (miso),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .idle      (idle),
        .busy      (busy),
        .data_valid(data_valid),
        .data_ch   (data_ch),
        .data      (data),
`ifdef SPI_RX_SCANNER_FAULT_EN
        .fault     (fault),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    // Reference model: channels served in ascending index order, fixed frame period;
    // start held high relaunches a scan two cycles after the previous select finds nothing left.
    task automatic build_expect(input logic [3:0] m, input int hold_k);
        int launch;
        int n;
        exp_dv_k.delete(); exp_dv_ch.delete(); exp_dv_data.delete(); exp_done_k.delete();
        launch = 0;
        for (int s = 0; s < 4; s++) begin
            n = 0;
            for (int c = 0; c < NCH; c++) begin
                if (m[c]) begin
                    exp_dv_k.push_back(launch + FRAME_PERIOD * n + DV_OFS);
                    exp_dv_ch.push_back(c);
                    exp_dv_data.push_back(words[c]);
                    n++;
                end
            end
            exp_done_k.push_back(launch + FRAME_PERIOD * n + 2);
            launch = launch + FRAME_PERIOD * n + 2;
            if (launch > hold_k - 1) break;
        end
    endtask

    // Launches a scan and records what the pins do; k counts cycles after the start-sampling edge.
    task automatic run_scan(input logic [3:0] m, input int hold_k, input int n_cyc,
                            input bit poke, input int abort_rises);
        logic prev_sclk;
        bit   prev_cs_high, seen_frame;
        int   gap, high_run, r, ch, idx;
        obs_dv_k.delete(); obs_dv_ch.delete(); obs_dv_data.delete(); obs_done_k.delete();
        obs_rises = 0; obs_multi_low = 0; obs_bad_high = 0; obs_min_gap = 1000;
        obs_any_cs_low = 0; obs_aborted = 0;
        obs_data_start = data;
        @(negedge clk);
        ch_mask = m;
        start   = 1'b1;
        @(posedge clk);
        prev_sclk = sclk; prev_cs_high = 1; seen_frame = 0;
        gap = 0; high_run = 0; r = 0; ch = 0;
        for (int k = 1; k <= n_cyc; k++) begin
            @(negedge clk);
            if (k == hold_k) start = 1'b0;
            if (poke && k == 30) begin start = 1'b1; ch_mask = 4'hF; end
            if (poke && k == 31) start = 1'b0;
            if (k == 2) obs_cs_k2 = cs_n;
`ifdef SPI_RX_SCANNER_FAULT_EN
            if (k == 2) obs_fault_k2 = fault;
`endif
            if (data_valid) begin
                obs_dv_k.push_back(k);
                obs_dv_ch.push_back(int'(data_ch));
                obs_dv_data.push_back(data);
            end
            if (done) obs_done_k.push_back(k);
            if ($countones(~cs_n) > 1) obs_multi_low++;
            if (cs_n != 4'hF) begin
                obs_any_cs_low = 1;
                if (prev_cs_high) begin
                    if (seen_frame && gap < obs_min_gap) obs_min_gap = gap;
                    seen_frame = 1;
                    r = 0;
                    for (int c = 0; c < NCH; c++) if (!cs_n[c]) ch = c;
                end
                prev_cs_high = 0;
            end else begin
                if (!prev_cs_high) gap = 0;
                gap++;
                prev_cs_high = 1;
            end
            // Sensor shifts its next bit out after each rising SCLK edge
            if (sclk && !prev_sclk) begin
                obs_rises++;
                r++;
                high_run = 1;
                if (r >= 1 && r <= FB) begin
                    idx  = FB - r;
                    miso = words[ch][idx];
                end
            end else if (sclk) begin
                high_run++;
            end else if (prev_sclk && high_run != CDH) begin
                obs_bad_high++;
            end
            prev_sclk = sclk;
            if (abort_rises > 0 && obs_rises == abort_rises && !sclk) begin
                #2 rst = 1'b1;
                #1;
                snap_cs = cs_n; snap_sclk = sclk; snap_idle = idle; snap_busy = busy;
                snap_dv = data_valid; snap_done = done;
                obs_aborted = 1;
                break;
            end
        end
        obs_data_end = data;
`ifdef SPI_RX_SCANNER_FAULT_EN
        obs_fault_end = fault;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ch_mask = 4'h0; miso = 1'b0;
        #3;
        n_cmp++;
        if ({sclk, cs_n, idle, busy, data_valid, done} !== {1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_ctrl: got sclk=%b cs_n=%b idle=%b busy=%b dv=%b done=%b, want 0 1111 1 0 0 0",
                     sclk, cs_n, idle, busy, data_valid, done);
        end
        n_cmp++;
        if ({data_ch, data} !== 18'h0) begin
            n_err++;
            $display("FAIL reset_data: got ch=%0d data=%h, want 0 0000", data_ch, data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        words[0] = 16'hA5C3;
        run_scan(4'b0001, 1, 90, 0, 0);
        n_cmp++;
        if (obs_cs_k2 !== 4'b1110) begin
            n_err++; $display("FAIL single_cs: got %b, want 1110", obs_cs_k2);
        end
        n_cmp++;
        if (obs_rises != 16 || obs_bad_high != 0) begin
            n_err++; $display("FAIL single_sclk: got rises=%0d bad_high=%0d, want 16 0", obs_rises, obs_bad_high);
        end
        n_cmp++;
        if (obs_dv_k.size() != 1 || obs_dv_k[0] != 70 || obs_dv_ch[0] != 0 || obs_dv_data[0] !== 16'hA5C3) begin
            n_err++;
            $display("FAIL single_dv: got n=%0d k=%0d ch=%0d data=%h, want 1 70 0 a5c3", obs_dv_k.size(),
                     (obs_dv_k.size() > 0) ? obs_dv_k[0] : -1, (obs_dv_ch.size() > 0) ? obs_dv_ch[0] : -1,
                     (obs_dv_data.size() > 0) ? obs_dv_data[0] : 16'hxxxx);
        end
        n_cmp++;
        if (obs_done_k.size() != 1 || obs_done_k[0] != 75) begin
            n_err++;
            $display("FAIL single_done: got n=%0d k=%0d, want 1 75", obs_done_k.size(),
                     (obs_done_k.size() > 0) ? obs_done_k[0] : -1);
        end
    endtask

    task automatic test_scan_order();
        words[1] = 16'h1234;
        words[3] = 16'hFFFE;
        run_scan(4'b1010, 1, 2 * FRAME_PERIOD + 20, 0, 0);
        n_cmp++;
        if (obs_dv_k.size() != 2) begin
            n_err++; $display("FAIL order_count: got %0d strobes, want 2", obs_dv_k.size());
        end else begin
            n_cmp++;
            if (obs_dv_ch[0] != 1 || obs_dv_data[0] !== 16'h1234 || obs_dv_ch[1] != 3 || obs_dv_data[1] !== 16'hFFFE) begin
                n_err++;
                $display("FAIL order_words: got (%0d,%h) (%0d,%h), want (1,1234) (3,fffe)",
                         obs_dv_ch[0], obs_dv_data[0], obs_dv_ch[1], obs_dv_data[1]);
            end
        end
        n_cmp++;
        if (obs_multi_low != 0) begin
            n_err++; $display("FAIL order_onehot: got %0d multi-low cycles, want 0", obs_multi_low);
        end
        n_cmp++;
        if (obs_min_gap < CSH) begin
            n_err++; $display("FAIL order_gap: got %0d high cycles, want >= %0d", obs_min_gap, CSH);
        end
    endtask

    task automatic test_empty_mask();
        run_scan(4'b0000, 1, 12, 0, 0);
        n_cmp++;
        if (obs_done_k.size() != 1 || obs_done_k[0] != 2) begin
            n_err++;
            $display("FAIL empty_done: got n=%0d k=%0d, want 1 2", obs_done_k.size(),
                     (obs_done_k.size() > 0) ? obs_done_k[0] : -1);
        end
        n_cmp++;
        if (obs_dv_k.size() != 0 || obs_rises != 0 || obs_any_cs_low) begin
            n_err++;
            $display("FAIL empty_quiet: got dv=%0d rises=%0d cs_low=%0d, want 0 0 0",
                     obs_dv_k.size(), obs_rises, obs_any_cs_low);
        end
        n_cmp++;
        if (obs_data_end !== obs_data_start) begin
            n_err++; $display("FAIL empty_hold: got data=%h, want %h", obs_data_end, obs_data_start);
        end
    endtask

    task automatic test_ignore_busy();
        for (int c = 0; c < NCH; c++) words[c] = 16'($urandom);
        run_scan(4'b0001, 1, 95, 1, 0);
        n_cmp++;
        if (obs_dv_k.size() != 1 || obs_dv_ch[0] != 0 || obs_dv_data[0] !== words[0]) begin
            n_err++;
            $display("FAIL busy_dv: got n=%0d ch=%0d data=%h, want 1 0 %h", obs_dv_k.size(),
                     (obs_dv_ch.size() > 0) ? obs_dv_ch[0] : -1,
                     (obs_dv_data.size() > 0) ? obs_dv_data[0] : 16'hxxxx, words[0]);
        end
        n_cmp++;
        if (obs_done_k.size() != 1) begin
            n_err++; $display("FAIL busy_done: got %0d pulses, want 1", obs_done_k.size());
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        words[0] = 16'h5A3C;
        run_scan(4'b0001, 1, 100, 0, 7);
        n_cmp++;
        if (!obs_aborted) begin
            n_err++; $display("FAIL rmid_reach: got aborted=0, want 1 (7 sclk pulses not seen)");
        end
        n_cmp++;
        if ({snap_cs, snap_sclk, snap_idle, snap_busy, snap_dv, snap_done} !== {4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rmid_async: got cs_n=%b sclk=%b idle=%b busy=%b dv=%b done=%b, want 1111 0 1 0 0 0",
                     snap_cs, snap_sclk, snap_idle, snap_busy, snap_dv, snap_done);
        end
        bad = 0;
        repeat (3) @(negedge clk) if (data_valid || done) bad++;
        rst = 1'b0;
        repeat (4) @(negedge clk) if (data_valid || done || !idle) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL rmid_quiet: got %0d bad cycles, want 0", bad);
        end
        words[0] = 16'hC3A5;
        build_expect(4'b0001, 1);
        run_scan(4'b0001, 1, 90, 0, 0);
        n_cmp++;
        if (obs_dv_k.size() != 1 || obs_dv_k[0] != exp_dv_k[0] || obs_dv_data[0] !== 16'hC3A5) begin
            n_err++;
            $display("FAIL rmid_relaunch: got n=%0d k=%0d data=%h, want 1 %0d c3a5", obs_dv_k.size(),
                     (obs_dv_k.size() > 0) ? obs_dv_k[0] : -1,
                     (obs_dv_data.size() > 0) ? obs_dv_data[0] : 16'hxxxx, exp_dv_k[0]);
        end
    endtask

    task automatic test_back_to_back();
        words[0] = 16'($urandom);
        build_expect(4'b0001, 76);
        run_scan(4'b0001, 76, 165, 0, 0);
        n_cmp++;
        if (obs_dv_k.size() != exp_dv_k.size() || obs_done_k.size() != exp_done_k.size()) begin
            n_err++;
            $display("FAIL b2b_count: got dv=%0d done=%0d, want %0d %0d", obs_dv_k.size(),
                     obs_done_k.size(), exp_dv_k.size(), exp_done_k.size());
        end else begin
            foreach (exp_dv_k[i]) begin
                n_cmp++;
                if (obs_dv_k[i] != exp_dv_k[i] || obs_dv_data[i] !== exp_dv_data[i] || obs_done_k[i] != exp_done_k[i]) begin
                    n_err++;
                    $display("FAIL b2b_scan%0d: got dv@%0d %h done@%0d, want dv@%0d %h done@%0d", i,
                             obs_dv_k[i], obs_dv_data[i], obs_done_k[i], exp_dv_k[i], exp_dv_data[i], exp_done_k[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] m;
        int hold_k, n_cyc;
        for (int it = 0; it < 6; it++) begin
            m = 4'($urandom_range(0, 15));
            for (int c = 0; c < NCH; c++) words[c] = 16'($urandom);
            hold_k = ($urandom_range(0, 2) == 0) ? FRAME_PERIOD * $countones(m) + 3 : 1;
            build_expect(m, hold_k);
            n_cyc = exp_done_k[exp_done_k.size() - 1] + 8;
            run_scan(m, hold_k, n_cyc, 0, 0);
            n_cmp++;
            if (obs_dv_k.size() != exp_dv_k.size()) begin
                n_err++;
                $display("FAIL rand%0d_dv_count: got %0d, want %0d (mask %b)", it, obs_dv_k.size(), exp_dv_k.size(), m);
            end else begin
                foreach (exp_dv_k[i]) begin
                    n_cmp++;
                    if (obs_dv_k[i] != exp_dv_k[i] || obs_dv_ch[i] != exp_dv_ch[i] || obs_dv_data[i] !== exp_dv_data[i]) begin
                        n_err++;
                        $display("FAIL rand%0d_dv%0d: got k=%0d ch=%0d data=%h, want k=%0d ch=%0d data=%h", it, i,
                                 obs_dv_k[i], obs_dv_ch[i], obs_dv_data[i], exp_dv_k[i], exp_dv_ch[i], exp_dv_data[i]);
                    end
                end
            end
            n_cmp++;
            if (obs_done_k.size() != exp_done_k.size() || obs_done_k[0] != exp_done_k[0]) begin
                n_err++;
                $display("FAIL rand%0d_done: got n=%0d first=%0d, want %0d %0d", it, obs_done_k.size(),
                         (obs_done_k.size() > 0) ? obs_done_k[0] : -1, exp_done_k.size(), exp_done_k[0]);
            end
            n_cmp++;
            if (obs_rises != FB * exp_dv_k.size() || obs_bad_high != 0 || obs_multi_low != 0) begin
                n_err++;
                $display("FAIL rand%0d_pins: got rises=%0d bad_high=%0d multi_low=%0d, want %0d 0 0", it,
                         obs_rises, obs_bad_high, obs_multi_low, FB * exp_dv_k.size());
            end
            n_cmp++;
            if (obs_data_end !== ((exp_dv_data.size() > 0) ? exp_dv_data[exp_dv_data.size() - 1] : obs_data_start)) begin
                n_err++;
                $display("FAIL rand%0d_hold: got data=%h after done, want last captured word", it, obs_data_end);
            end
        end
    endtask

`ifdef SPI_RX_SCANNER_FAULT_EN
    task automatic test_fault();
        words[2] = 16'h0004;
        run_scan(4'b0100, 1, 90, 0, 0);
        n_cmp++;
        if (obs_fault_end !== 4'b0100) begin
            n_err++; $display("FAIL fault_set: got %b, want 0100", obs_fault_end);
        end
        words[2] = 16'h0000;
        run_scan(4'b0100, 1, 90, 0, 0);
        n_cmp++;
        if (obs_fault_k2 !== 4'b0000 || obs_fault_end !== 4'b0000) begin
            n_err++; $display("FAIL fault_clear: got early=%b end=%b, want 0000 0000", obs_fault_k2, obs_fault_end);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_scan_order();
        test_empty_mask();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef SPI_RX_SCANNER_FAULT_EN
        test_fault();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
